// File: rtl/shift_denorm.sv
// shift_denorm: multi-cycle logical right shifter for denormalization.
// The shift amount is applied one binary weight per cycle (1, 2, 4, ...).
// The result is valid a fixed LZC_WIDTH cycles after accept.
// The sticky output is the OR of every 1-bit shifted out.
//
// Ports:
//   clk        : clock; all state changes on the rising edge
//   rstn       : asynchronous active-low reset
//   in_valid   : request valid
//   in_ready   : block is idle and can accept a request
//   in_data    : normalized operand, I_WIDTH bits
//   in_shamt   : right-shift amount, LZC_WIDTH bits
//   out_valid  : result valid; held until out_ready
//   out_ready  : consumer accepts the result
//   out_data   : in_data >> in_shamt (zero fill)
//   out_sticky : OR of all bits shifted out
//
// Build option:
//   SHIFT_DENORM_STICKY_EN : when defined, sticky is accumulated.
//                            When undefined, out_sticky is tied to 0.

module shift_denorm #(
    parameter int LZC_WIDTH = 7,
    parameter int I_WIDTH   = 2**(LZC_WIDTH-1)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [I_WIDTH-1:0]   in_data,
    input  logic [LZC_WIDTH-1:0] in_shamt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [I_WIDTH-1:0]   out_data,
    output logic                 out_sticky
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [LZC_WIDTH-1:0] r_cnt;
    logic [LZC_WIDTH-1:0] r_shamt;
    logic [I_WIDTH-1:0]   r_data;

    logic                 w_accept;
    logic                 w_last;
    logic [31:0]          w_wt;
    logic [I_WIDTH-1:0]   w_shifted;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_data  = r_data;

    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_last    = (r_cnt == LZC_WIDTH'(LZC_WIDTH-1));

    // Weight of the current step; a weight >= I_WIDTH shifts to zero.
    assign w_wt      = 32'd1 << r_cnt;
    assign w_shifted = r_data >> w_wt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // The shift amount is consumed LSB-first so bit 0 always
    // selects whether the current weight is applied.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_data  <= '0;
            r_shamt <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_data  <= in_data;
            r_shamt <= in_shamt;
            r_cnt   <= '0;
        end else if (r_state == SHIFT) begin
            if (r_shamt[0]) begin
                r_data <= w_shifted;
            end
            r_shamt <= r_shamt >> 1;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

`ifdef SHIFT_DENORM_STICKY_EN
    logic               r_sticky;
    logic [I_WIDTH-1:0] w_drop;

    // Bits below the step weight fall off; a huge weight drops all.
    assign w_drop = r_data & ~({I_WIDTH{1'b1}} << w_wt);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sticky <= 1'b0;
        end else if (w_accept) begin
            r_sticky <= 1'b0;
        end else if ((r_state == SHIFT) && r_shamt[0]) begin
            r_sticky <= r_sticky | (|w_drop);
        end
    end

    assign out_sticky = r_sticky;
`else
    assign out_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_shift_denorm.sv
// tb_shift_denorm: directed self-checking bench for shift_denorm.
// Sticky expectations adapt to SHIFT_DENORM_STICKY_EN.

module tb_shift_denorm;

    localparam int LW = 7;
    localparam int W  = 64;
`ifdef SHIFT_DENORM_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic          clk;
    logic          rstn;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [LW-1:0] in_shamt;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_sticky;

    int total;
    int bad;

    shift_denorm #(.LZC_WIDTH(LW), .I_WIDTH(W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_shamt   (in_shamt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sticky (out_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request from IDLE, wait for out_valid (bounded),
    // capture the result, then consume it.
    task automatic do_op(input logic [W-1:0] d, input logic [LW-1:0] s,
                         output int lat, output logic [W-1:0] rd,
                         output logic rs, output bit tmo);
        lat = 0;
        tmo = 1'b1;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '1;
        in_shamt = '1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) begin
                tmo = 1'b0;
                break;
            end
        end
        rd = out_data;
        rs = out_sticky;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        out_ready = 1'b0;
        #2;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs: rdy=%b vld=%b want 1 0",
                     in_ready, out_valid);
        end
        total++;
        if (out_data !== 64'd0 || out_sticky !== 1'b0) begin
            bad++;
            $display("FAIL reset_data: data=%h stk=%b want 0 0",
                     out_data, out_sticky);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_shift_cases();
        logic [W-1:0]  vd [10];
        logic [LW-1:0] vs [10];
        logic [W-1:0]  ed [10];
        logic          es [10];
        int            lat;
        logic [W-1:0]  rd;
        logic          rs;
        bit            tmo;
        vd[0] = 64'h8000_0000_0000_0000; vs[0] = 7'd63;
        ed[0] = 64'h1;                   es[0] = 1'b0;
        vd[1] = 64'hFF;                  vs[1] = 7'd4;
        ed[1] = 64'hF;                   es[1] = 1'b1;
        vd[2] = 64'hFF;                  vs[2] = 7'd0;
        ed[2] = 64'hFF;                  es[2] = 1'b0;
        vd[3] = 64'h1;                   vs[3] = 7'd64;
        ed[3] = 64'h0;                   es[3] = 1'b1;
        vd[4] = 64'h1;                   vs[4] = 7'd127;
        ed[4] = 64'h0;                   es[4] = 1'b1;
        vd[5] = 64'h0;                   vs[5] = 7'd100;
        ed[5] = 64'h0;                   es[5] = 1'b0;
        vd[6] = 64'hDEAD_BEEF_0123_4567; vs[6] = 7'd8;
        ed[6] = 64'h00DE_ADBE_EF01_2345; es[6] = 1'b1;
        vd[7] = 64'h8000_0000_0000_0000; vs[7] = 7'd127;
        ed[7] = 64'h0;                   es[7] = 1'b1;
        vd[8] = 64'h10;                  vs[8] = 7'd5;
        ed[8] = 64'h0;                   es[8] = 1'b1;
        vd[9] = 64'h100;                 vs[9] = 7'd8;
        ed[9] = 64'h1;                   es[9] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            do_op(vd[i], vs[i], lat, rd, rs, tmo);
            total++;
            if (tmo || lat != 7) begin
                bad++;
                $display("FAIL case%0d_lat: got %0d want 7", i, lat);
            end
            total++;
            if (rd !== ed[i]) begin
                bad++;
                $display("FAIL case%0d_data: got %h want %h",
                         i, rd, ed[i]);
            end
            total++;
            if (rs !== (es[i] & STK)) begin
                bad++;
                $display("FAIL case%0d_sticky: got %b want %b",
                         i, rs, es[i] & STK);
            end
        end
    endtask

    task automatic test_hold();
        bit ok;
        in_valid = 1'b1;
        in_data  = 64'hABCD_0000_0000_0000;
        in_shamt = 7'd16;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 64'h1234;
        in_shamt = 7'd0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL hold_wait: out_valid=0 want 1");
        end
        for (int i = 0; i < 5; i++) begin
            // Changing inputs in DONE must be ignored.
            in_valid = 1'b1;
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                out_data !== 64'h0000_ABCD_0000_0000) begin
                bad++;
                $display("FAIL hold_c%0d: vld=%b rdy=%b data=%h want 1 0 %h",
                         i, out_valid, in_ready, out_data,
                         64'h0000_ABCD_0000_0000);
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL hold_consume_rdy: got %b want 0", in_ready);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold_after: rdy=%b vld=%b want 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int acc [$];
        bit a;
        in_valid  = 1'b1;
        in_data   = 64'hF0;
        in_shamt  = 7'd4;
        out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            a = in_valid && in_ready;
            if (out_valid) begin
                total++;
                if (out_data !== 64'hF || out_sticky !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_data: got %h %b want f 0",
                             out_data, out_sticky);
                end
            end
            @(posedge clk);
            if (a) acc.push_back(c);
        end
        in_valid  = 1'b0;
        #1;
        total++;
        if (acc.size() < 3) begin
            bad++;
            $display("FAIL b2b_count: got %0d accepts want >=3", acc.size());
        end else begin
            for (int k = 1; k < 3; k++) begin
                total++;
                if (acc[k] - acc[k-1] != 9) begin
                    bad++;
                    $display("FAIL b2b_gap%0d: got %0d want 9",
                             k, acc[k] - acc[k-1]);
                end
            end
        end
        // Drain any in-flight op back to IDLE.
        for (int i = 0; i < 12 && !in_ready; i++) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midshift();
        bit spur;
        bit ok;
        in_valid = 1'b1;
        in_data  = 64'hFFFF;
        in_shamt = 7'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
            out_data !== 64'd0 || out_sticky !== 1'b0) begin
            bad++;
            $display("FAIL midrst: rdy=%b vld=%b data=%h stk=%b want 1 0 0 0",
                     in_ready, out_valid, out_data, out_sticky);
        end
        @(negedge clk);
        rstn = 1'b1;
        spur = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) spur = 1'b1;
        end
        total++;
        if (spur) begin
            bad++;
            $display("FAIL midrst_spur: out_valid=1 want 0");
        end
        // Request pending while reset releases is taken on the first edge.
        rstn     = 1'b0;
        in_valid = 1'b1;
        in_data  = 64'h3;
        in_shamt = 7'd1;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rel_accept: rdy=%b want 0", in_ready);
        end
        ok = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
        end
        if (out_valid) ok = 1'b1;
        total++;
        if (!ok || out_data !== 64'h1 || out_sticky !== STK) begin
            bad++;
            $display("FAIL rel_result: vld=%b data=%h stk=%b want 1 1 %b",
                     out_valid, out_data, out_sticky, STK);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_shift_cases();
        test_hold();
        test_back_to_back();
        test_reset_midshift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_denorm.md
SHIFT_DENORM -- requirements
Module: shift_denorm

Interface
REQ-001 SHALL have parameter LZC_WIDTH, default 7, shift-amount width (same encoding as the leading-zero-count unit output).
REQ-002 SHALL have parameter I_WIDTH, default 2**(LZC_WIDTH-1), data width.
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port in_data  input  I_WIDTH  normalized operand.
REQ-008 SHALL have port in_shamt  input  LZC_WIDTH  right-shift amount, 0..2**LZC_WIDTH-1.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out_data  output  I_WIDTH  in_data logically right-shifted by in_shamt.
REQ-012 SHALL have port out_sticky  output  1  OR of all 1-bits shifted out.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 SHALL accept a request on a rising edge with in_valid & in_ready: capture in_data, in_shamt; clear sticky; cnt=0; go SHIFT.
REQ-015 SHALL, on each SHIFT edge, shift the working register right by 2**cnt if in_shamt[cnt]=1 (zero-fill), OR the dropped bits into sticky, then cnt=cnt+1.
REQ-016 SHALL leave SHIFT for DONE on the edge that processes cnt=LZC_WIDTH-1; cnt is LZC_WIDTH-bit-safe (no wrap before exit).
REQ-017 SHALL have fixed latency: request accepted at edge N -> out_valid high from edge N+LZC_WIDTH, independent of in_shamt (including 0).
REQ-018 SHALL treat shift steps with weight >= I_WIDTH as clearing the whole working register and ORing all its bits into sticky; in_shamt >= I_WIDTH yields out_data=0, out_sticky=|in_data.
REQ-019 SHALL hold out_data, out_sticky, out_valid stable in DONE until out_ready=1 at an edge, then go IDLE.
REQ-020 SHALL not accept a new request in the same cycle a result is consumed; in_ready rises the cycle after DONE->IDLE.
REQ-021 SHALL ignore in_valid/in_data/in_shamt changes while not in IDLE.
REQ-022 SHALL keep out_data/out_sticky at their last values outside DONE (not meaningful; consumers qualify with out_valid).

Reset
REQ-023 SHALL, on rstn low, asynchronously set state=IDLE, cnt=0, working register=0, sticky=0; thus in_ready=1, out_valid=0, out_data=0, out_sticky=0.
REQ-024 SHALL abandon any in-flight operation when reset asserts in SHIFT or DONE; no result is produced after release.
REQ-025 SHALL leave reset on the first rising clk edge after rstn deasserts, accepting a request on that edge if in_valid=1.

Configuration
REQ-026 SHALL use macro SHIFT_DENORM_STICKY_EN: defined -> sticky accumulated per REQ-015/018; undefined -> sticky logic absent and out_sticky tied 0, all else unchanged.

Verification (LZC_WIDTH=7, I_WIDTH=64, SHIFT_DENORM_STICKY_EN defined unless noted)
REQ-027 SHALL cover: in_data=0x8000_0000_0000_0000, in_shamt=63 -> out_data=0x1, out_sticky=0, out_valid exactly 7 edges after accept.
REQ-028 SHALL cover: in_data=0xFF, in_shamt=4 -> out_data=0xF, out_sticky=1; in_shamt=0 -> out_data=0xFF, out_sticky=0, same 7-edge latency.
REQ-029 SHALL cover: in_data=0x1, in_shamt=64 and in_shamt=127 -> out_data=0, out_sticky=1; in_data=0, in_shamt=100 -> out_data=0, out_sticky=0.
REQ-030 SHALL cover: out_ready low 5 cycles in DONE -> out_valid, out_data held, in_ready=0 throughout; accept then in_ready=1 next cycle; in_valid held high gives back-to-back accepts every 9 cycles.
REQ-031 SHALL cover: rstn pulsed low mid-SHIFT (cnt=3) -> immediately in_ready=1, out_valid=0, out_data=0; no spurious out_valid afterwards.
REQ-032 SHALL cover: macro undefined, in_data=0xFF, in_shamt=4 -> out_data=0xF, out_sticky=0.
